video_fetch_buf: RTL and testbench
==================================

VIDEO_FETCH_BUF -- requirements
Module: video_fetch_buf

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in 16-bit words; SHALL be a power of two, 4..16.
REQ-002 Parameter MAXOUT, default 3, maximum DRAM video requests in flight; SHALL be at least 1 and less than DEPTH.
REQ-003 clk  in  1  28 MHz system clock; all state SHALL be on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 fetch_en  in  1  fetch window active (vpix-qualified) from the sync generator.
REQ-006 line_start  in  1  one-clock pulse at the start of each line; flushes the buffer.
REQ-007 int_start  in  1  one-clock frame-start pulse; clears the sticky error flags.
REQ-008 video_go  out  1  request to the DRAM arbiter to fetch the next video word.
REQ-009 video_next  in  1  arbiter accepted a request; the address generator advances on the same pulse.
REQ-010 video_strobe  in  1  returned DRAM data valid this clock.
REQ-011 video_data  in  16  returned DRAM word.
REQ-012 pix_rd  in  1  renderer pops one word.
REQ-013 pix_data  out  16  head word; registered, updated on a successful pop.
REQ-014 pix_empty  out  1  FIFO holds no words.
REQ-015 underrun  out  1  sticky: pix_rd was seen while empty.
REQ-016 overflow  out  1  sticky: video_strobe was seen with no request outstanding, or with the FIFO full.

Function
REQ-017 Counters SHALL be: occ (0..DEPTH), outst (0..MAXOUT) and discard (0..MAXOUT), each of width clog2(DEPTH)+1.
REQ-018 video_go SHALL be combinational and high iff fetch_en & !line_start & (occ+outst < DEPTH) & (outst < MAXOUT).
REQ-019 Request counting:
- video_next SHALL increment outst.
- video_strobe SHALL decrement outst, or decrement discard first when discard is nonzero.
- Simultaneous video_next and video_strobe SHALL leave the counter net unchanged.
REQ-020 Write: a video_strobe that is not discarded and arrives while the FIFO is not full SHALL write video_data at the write pointer, which then increments modulo DEPTH.
REQ-021 Read: pix_rd while !pix_empty SHALL load the head word into pix_data on the next clock and increment the read pointer modulo DEPTH.
REQ-022 Pop to pix_data latency SHALL be 1 clock.
REQ-023 A write into an empty FIFO SHALL make pix_empty low on the next clock.
REQ-024 pix_rd while pix_empty SHALL leave the pointers and pix_data unchanged and set underrun.
REQ-025 A simultaneous write and read SHALL leave occ unchanged, with both pointers advancing.
REQ-026 A video_strobe with outst==0 and discard==0 SHALL be dropped and set overflow.
REQ-027 A non-discarded video_strobe while occ==DEPTH SHALL be dropped and set overflow.
REQ-028 line_start flush, taking effect on the next clock:
- occ and both pointers SHALL go to 0 and pix_empty high.
- discard SHALL be loaded with discard+outst, saturating at MAXOUT.
- outst SHALL be cleared.
- A video_next in the same clock SHALL also count into discard.
- Any write or read in that clock SHALL be ignored.
REQ-029 line_start SHALL take priority over int_start.
REQ-030 int_start SHALL clear underrun and overflow; a set event in the same clock SHALL win.
REQ-031 fetch_en falling SHALL stop new requests only; in-flight data SHALL still be written.

Reset
REQ-032 On rst_n low the block SHALL set: pointers, occ, outst and discard to 0; pix_data 16'h0000; pix_empty 1; underrun 0; overflow 0; video_go 0.
REQ-033 Reset SHALL be asserted asynchronously and released synchronously via a two-flop synchroniser of rst_n in clk.
REQ-034 Reset mid-line SHALL discard all state; stale strobes after release SHALL set overflow.

Structure
REQ-035 DEPTH and MAXOUT defaults and the counter-width function SHALL live in the shared video package.
REQ-036 Storage SHALL be one sub-module, video_fifo_ram: a DEPTH x 16 simple dual-port RAM with a registered read.
REQ-037 Counters and control SHALL remain in video_fetch_buf.

Verification
REQ-038 Fill: fetch_en=1, arbiter grants every clock, strobe 2 clocks later, no pix_rd -> exactly 8 video_next pulses; then video_go=0, occ=8, overflow=0.
REQ-039 Order: strobes carry 16'h0001..16'h0008; 8 pops -> pix_data 0001..0008, each 1 clock after its pop; then pix_empty=1.
REQ-040 Flush: 2 outstanding, occ=5, line_start -> occ=0, discard=2; the next 2 strobes are not stored; the third (A5A5) is stored.
REQ-041 Underrun: pix_rd on empty -> underrun=1 and pix_data unchanged; int_start -> underrun=0.
REQ-042 Simultaneous: occ=4, write and pop in the same clock -> occ=4; strobe with outst=0, discard=0 -> overflow=1.
REQ-043 Reset: rst_n low mid-fill with 3 outstanding -> outputs go to their reset values immediately; after release, one stale strobe -> overflow=1.

Source files
------------

// File: rtl/video_fetch_buf_pkg.sv
// Shared video fetch definitions: default buffer geometry, the counter
// width helper and the classification of a returning DRAM strobe.
package video_fetch_buf_pkg;

  localparam int VID_DEPTH  = 8;
  localparam int VID_MAXOUT = 3;
  localparam int VID_DATA_W = 16;

  // What a video_strobe does in the current clock, decided before any
  // counter or storage update so every consumer sees the same answer.
  typedef enum logic [2:0] {
    STB_NONE,
    STB_DISCARD,
    STB_WRITE,
    STB_DROP_FULL,
    STB_DROP_ORPHAN
  } strobe_kind_e;

  // Counters must hold 0..DEPTH inclusive, hence one bit more than the
  // pointer width.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/video_fetch_buf_if.sv
// Bus bundle between the sync generator / DRAM arbiter / renderer and the
// video fetch buffer. The slave side is the buffer itself.
interface video_fetch_buf_if;
  import video_fetch_buf_pkg::*;

  logic                  fetch_en;
  logic                  line_start;
  logic                  int_start;
  logic                  video_go;
  logic                  video_next;
  logic                  video_strobe;
  logic [VID_DATA_W-1:0] video_data;
  logic                  pix_rd;
  logic [VID_DATA_W-1:0] pix_data;
  logic                  pix_empty;
  logic                  underrun;
  logic                  overflow;

  modport slave (
    input  fetch_en, line_start, int_start, video_next, video_strobe,
           video_data, pix_rd,
    output video_go, pix_data, pix_empty, underrun, overflow
  );

  modport master (
    output fetch_en, line_start, int_start, video_next, video_strobe,
           video_data, pix_rd,
    input  video_go, pix_data, pix_empty, underrun, overflow
  );

endinterface

// File: rtl/video_fifo_ram.sv
// DEPTH x 16 simple dual-port storage for the video fetch buffer. The read
// port is registered so the popped word appears one clock after the pop.
module video_fifo_ram
  import video_fetch_buf_pkg::*;
#(
  parameter int DEPTH = VID_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [VID_DATA_W-1:0]    i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [VID_DATA_W-1:0]    o_rd_data
);

  logic [VID_DATA_W-1:0] r_mem [DEPTH];
  logic [VID_DATA_W-1:0] r_q;

  // Storage array is never reset; only the occupancy logic decides validity.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Output register holds the last popped word until the next pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_q <= '0;
    else if (i_rd_en) r_q <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/video_fetch_buf.sv
// Line-based video word prefetch buffer: issues DRAM requests while the
// fetch window is open and there is room for the answers, stores returned
// words, hands them to the renderer, and throws away answers to requests
// that were in flight when a new line flushed the buffer.
module video_fetch_buf
  import video_fetch_buf_pkg::*;
#(
  parameter int DEPTH  = VID_DEPTH,
  parameter int MAXOUT = VID_MAXOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  video_fetch_buf_if.slave   bus
);

  localparam int CW = cntWidth(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MAXOUT_C = CW'(MAXOUT);

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;

  logic [CW-1:0] r_occ, r_outst, r_discard;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_underrun, r_overflow;

  logic [CW-1:0] w_occ_nxt, w_outst_nxt, w_discard_nxt;
  logic [AW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic          w_underrun_nxt, w_overflow_nxt;

  strobe_kind_e  w_kind;
  logic          w_full, w_empty, w_wr, w_rd, w_consumed;
  logic [CW:0]   w_committed, w_inflight;
  logic [CW-1:0] w_flush_discard;

  // Reset asserts at once but releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_full  = (r_occ == DEPTH_C);
  assign w_empty = (r_occ == '0);

  // Decide the fate of a returning strobe: stale answers are eaten first,
  // answers with no matching request are orphans, the rest go to storage.
  always_comb begin
    w_kind = STB_NONE;
    if (bus.video_strobe) begin
      if (r_discard != '0)    w_kind = STB_DISCARD;
      else if (r_outst == '0) w_kind = STB_DROP_ORPHAN;
      else if (w_full)        w_kind = STB_DROP_FULL;
      else                    w_kind = STB_WRITE;
    end
  end

  assign w_consumed = (w_kind == STB_DISCARD) || (w_kind == STB_WRITE) ||
                      (w_kind == STB_DROP_FULL);
  assign w_wr = (w_kind == STB_WRITE) && !bus.line_start;
  assign w_rd = bus.pix_rd && !w_empty && !bus.line_start;

  // Only words already stored or already requested reserve buffer space.
  assign w_committed = {1'b0, r_occ} + {1'b0, r_outst};
  assign bus.video_go = w_rst_n && bus.fetch_en && !bus.line_start &&
                        (w_committed < (CW+1)'(DEPTH)) &&
                        (r_outst < MAXOUT_C);

  // On a flush every request still owed to us becomes a discard, including
  // one granted in the flush clock itself, capped at MAXOUT.
  assign w_inflight = {1'b0, r_discard} + {1'b0, r_outst} +
                      (CW+1)'(bus.video_next) - (CW+1)'(w_consumed);
  assign w_flush_discard = (w_inflight > (CW+1)'(MAXOUT)) ? MAXOUT_C
                                                           : w_inflight[CW-1:0];

  // Next-state for counters, pointers and sticky flags; line_start wins
  // over everything except the error-set events.
  always_comb begin
    w_occ_nxt      = r_occ;
    w_outst_nxt    = r_outst;
    w_discard_nxt  = r_discard;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_underrun_nxt = r_underrun;
    w_overflow_nxt = r_overflow;

    if (bus.line_start) begin
      w_occ_nxt     = '0;
      w_outst_nxt   = '0;
      w_discard_nxt = w_flush_discard;
      w_wr_ptr_nxt  = '0;
      w_rd_ptr_nxt  = '0;
    end else begin
      w_occ_nxt     = r_occ + CW'(w_wr) - CW'(w_rd);
      w_outst_nxt   = r_outst + CW'(bus.video_next) -
                      CW'((w_kind == STB_WRITE) || (w_kind == STB_DROP_FULL));
      w_discard_nxt = r_discard - CW'(w_kind == STB_DISCARD);
      w_wr_ptr_nxt  = r_wr_ptr + AW'(w_wr);
      w_rd_ptr_nxt  = r_rd_ptr + AW'(w_rd);
      if (bus.int_start) begin
        w_underrun_nxt = 1'b0;
        w_overflow_nxt = 1'b0;
      end
    end

    if (bus.pix_rd && w_empty) w_underrun_nxt = 1'b1;
    if ((w_kind == STB_DROP_ORPHAN) ||
        ((w_kind == STB_DROP_FULL) && !bus.line_start)) w_overflow_nxt = 1'b1;
  end

  // Register the control state from the synchronised reset.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_occ      <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_outst    <= w_outst_nxt;
      r_discard  <= w_discard_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_underrun <= w_underrun_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  video_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk     (clk),
    .i_rst_n   (w_rst_n),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.video_data),
    .i_rd_en   (w_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (bus.pix_data)
  );

  assign bus.pix_empty = w_empty;
  assign bus.underrun  = r_underrun;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_video_fetch_buf.sv
// Directed bench for video_fetch_buf: a driver emulates the arbiter and a
// two-clock DRAM, a scoreboard queue holds the words each pop must return.
module tb_video_fetch_buf;

  logic clk;
  logic rst_n;

  video_fetch_buf_if bus();

  video_fetch_buf #(.DEPTH(8), .MAXOUT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] expQ[$];
  bit          grantEn   = 0;
  int          nextCount = 0;
  logic [15:0] stbData   = 16'h0000;
  bit          pipe0V = 0, pipe1V = 0;
  logic [15:0] pipe0D = '0, pipe1D = '0;
  bit          popPending = 0;

  // 28 MHz system clock.
  initial clk = 1'b0;
  always #18 clk = ~clk;

  // Hard stop in case the bench itself wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock of stimulus: DRAM answers from two clocks ago, then the
  // requested inputs, then an auto-grant from video_go when enabled.
  task automatic applyStimulus(input bit fe, input bit ls, input bit is,
                               input bit rd, input bit nx, input bit stb,
                               input logic [15:0] d);
    @(posedge clk); #1;
    bus.video_strobe = pipe1V | stb;
    bus.video_data   = pipe1V ? pipe1D : d;
    pipe1V = pipe0V; pipe1D = pipe0D; pipe0V = 0;
    bus.fetch_en   = fe;
    bus.line_start = ls;
    bus.int_start  = is;
    bus.pix_rd     = rd;
    #1;
    bus.video_next = nx | (grantEn & bus.video_go);
    if (bus.video_next) begin
      nextCount++;
      if (grantEn) begin
        pipe0V = 1; pipe0D = stbData; stbData = stbData + 16'h1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 0, 0, 16'h0);
  endtask

  // Scoreboard monitor: a pop accepted in one clock must show its word on
  // pix_data by the following falling edge.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (!rst_n) popPending = 0;
    else begin
      if (popPending) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL pop_unexpected: got %h required no pop", bus.pix_data);
        end else begin
          exp = expQ.pop_front();
          if (bus.pix_data !== exp) begin
            failures++;
            $display("[TB] FAIL pop_data: got %h required %h", bus.pix_data, exp);
          end
        end
      end
      popPending = bus.pix_rd && !bus.pix_empty && !bus.line_start;
    end
  end

  initial begin
    rst_n = 0;
    bus.fetch_en = 1; bus.line_start = 0; bus.int_start = 0;
    bus.video_next = 0; bus.video_strobe = 0; bus.video_data = '0;
    bus.pix_rd = 0;
    #50;
    checkOutput("reset_go",       32'(bus.video_go),  0);
    checkOutput("reset_empty",    32'(bus.pix_empty), 1);
    checkOutput("reset_data",     32'(bus.pix_data),  0);
    checkOutput("reset_underrun", 32'(bus.underrun),  0);
    checkOutput("reset_overflow", 32'(bus.overflow),  0);
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0);
    rst_n = 1;
    idle(3);

    // Fill: grant every clock, answers two clocks later, no pops.
    grantEn = 1; stbData = 16'h0001; nextCount = 0;
    for (int i = 1; i <= 8; i++) expQ.push_back(16'(i));
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0, 0, 16'h0);
    checkOutput("fill_next_count", 32'(nextCount),   8);
    checkOutput("fill_go",         32'(bus.video_go), 0);
    checkOutput("fill_occ",        32'(dut.r_occ),   8);
    checkOutput("fill_overflow",   32'(bus.overflow), 0);
    grantEn = 0;

    // Order: drain all eight words.
    pops(8);
    idle(2);
    checkOutput("order_empty", 32'(bus.pix_empty), 1);
    checkOutput("order_last",  32'(bus.pix_data),  32'h0008);

    // Flush: five stored, two outstanding, then line_start.
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 1, 16'h0100 + 16'(i));
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0104);
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0);
    idle(1);
    checkOutput("flush_pre_occ",   32'(dut.r_occ),   5);
    checkOutput("flush_pre_outst", 32'(dut.r_outst), 2);
    applyStimulus(0, 1, 0, 0, 0, 0, 16'h0);
    idle(1);
    checkOutput("flush_occ",     32'(dut.r_occ),     0);
    checkOutput("flush_discard", 32'(dut.r_discard), 2);
    checkOutput("flush_empty",   32'(bus.pix_empty), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'hDEAD);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'hBEEF);
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'hA5A5);
    expQ.push_back(16'hA5A5);
    idle(1);
    checkOutput("flush_stored_occ", 32'(dut.r_occ),    1);
    checkOutput("flush_overflow",   32'(bus.overflow), 0);
    pops(1);
    idle(2);

    // Underrun, set-beats-clear, and line_start beating int_start.
    applyStimulus(0, 0, 0, 1, 0, 0, 16'h0);
    idle(1);
    checkOutput("underrun_set",  32'(bus.underrun),  1);
    checkOutput("underrun_data", 32'(bus.pix_data),  32'hA5A5);
    checkOutput("underrun_empty", 32'(bus.pix_empty), 1);
    applyStimulus(0, 0, 1, 1, 0, 0, 16'h0);
    idle(1);
    checkOutput("underrun_set_wins", 32'(bus.underrun), 1);
    applyStimulus(0, 1, 1, 0, 0, 0, 16'h0);
    idle(1);
    checkOutput("underrun_ls_priority", 32'(bus.underrun), 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h0);
    idle(1);
    checkOutput("underrun_clear", 32'(bus.underrun), 0);

    // Simultaneous write and pop at occ=4, then an orphan strobe.
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 0, 1, 1, 16'h0010 + 16'(i));
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0014);
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0);
    for (int i = 1; i <= 5; i++) expQ.push_back(16'h0010 + 16'(i));
    applyStimulus(0, 0, 0, 1, 0, 1, 16'h0015);
    idle(1);
    checkOutput("simul_occ", 32'(dut.r_occ), 4);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'hBAD0);
    idle(1);
    checkOutput("orphan_overflow", 32'(bus.overflow), 1);
    checkOutput("orphan_occ",      32'(dut.r_occ),    4);
    applyStimulus(0, 0, 1, 0, 0, 0, 16'h0);
    idle(1);
    checkOutput("overflow_clear", 32'(bus.overflow), 0);
    pops(4);
    idle(2);
    checkOutput("simul_empty", 32'(bus.pix_empty), 1);

    // Full: eight stored with one outstanding, its answer must be dropped.
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0);
    for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 0, 0, 1, 1, 16'h0020 + 16'(i));
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0029);
    for (int i = 1; i <= 8; i++) expQ.push_back(16'h0020 + 16'(i));
    idle(1);
    checkOutput("full_overflow", 32'(bus.overflow), 1);
    checkOutput("full_occ",      32'(dut.r_occ),    8);
    checkOutput("full_outst",    32'(dut.r_outst),  0);
    pops(8);
    idle(2);
    applyStimulus(0, 0, 0, 1, 0, 0, 16'h0);
    idle(1);

    // Reset mid-line: one word stored, three requests in flight.
    applyStimulus(0, 0, 0, 0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0031);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 16'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 16'h0);
    checkOutput("maxout_go",     32'(bus.video_go),  0);
    checkOutput("pre_rst_outst", 32'(dut.r_outst),   3);
    checkOutput("pre_rst_empty", 32'(bus.pix_empty), 0);
    checkOutput("pre_rst_flags", {30'd0, bus.underrun, bus.overflow}, 32'h3);
    #5;
    rst_n = 0;
    #1;
    checkOutput("rst_go",       32'(bus.video_go),  0);
    checkOutput("rst_empty",    32'(bus.pix_empty), 1);
    checkOutput("rst_data",     32'(bus.pix_data),  0);
    checkOutput("rst_flags",    {30'd0, bus.underrun, bus.overflow}, 0);
    checkOutput("rst_outst",    32'(dut.r_outst),   0);
    pipe0V = 0; pipe1V = 0;
    idle(2);
    rst_n = 1;
    idle(3);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0EEE);
    idle(1);
    checkOutput("stale_overflow", 32'(bus.overflow),  1);
    checkOutput("stale_empty",    32'(bus.pix_empty), 1);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
